// File: rtl/memacc_fifo_drain.sv
// Drains address/data entries from the MEMACC FIFO and turns them into memory writes
// at an auto-incrementing address. Define MEMACC_DRAIN_WRCNT_EN to build the write counter.
module memacc_fifo_drain (
   input  logic        wb_clk_i,
   input  logic        rst_i,
   input  logic        ft_memacc_rd_empty_i,
   output logic        ft_memacc_rd_req_o,
   input  logic        ft_memacc_ad_sel_i,
   input  logic [31:0] ft_memacc_ad_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_we_o,
   input  logic        mem_ack_i,
   output logic        addr_valid_o,
   output logic        err_o,
   output logic [15:0] wr_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_addrValid;
   logic        r_err;
   logic        w_rdReq;
   logic        w_loadAddr;
   logic        w_loadData;
   logic        w_setErr;
   logic        w_writeDone;

   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Popping only from IDLE is what lets a slow mem_ack_i back-pressure the FIFO.
   always_comb begin
      w_nextState = r_state;
      w_rdReq     = 1'b0;
      w_loadAddr  = 1'b0;
      w_loadData  = 1'b0;
      w_setErr    = 1'b0;
      w_writeDone = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_rdReq = ~ft_memacc_rd_empty_i & ~rst_i;
            if (w_rdReq) begin
               w_nextState = ST_LATCH;
            end
         end
         ST_LATCH: begin
            if (!ft_memacc_ad_sel_i) begin
               w_loadAddr  = 1'b1;
               w_nextState = ST_IDLE;
            end else if (r_addrValid) begin
               w_loadData  = 1'b1;
               w_nextState = ST_WRITE;
            end else begin
               w_setErr    = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (mem_ack_i) begin
               w_writeDone = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         r_addr      <= 32'd0;
         r_data      <= 32'd0;
         r_addrValid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_loadAddr) begin
            r_addr      <= ft_memacc_ad_i;
            r_addrValid <= 1'b1;
         end else if (w_writeDone) begin
            r_addr <= r_addr + 32'd1;
         end
         if (w_loadData) begin
            r_data <= ft_memacc_ad_i;
         end
         if (w_setErr) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef MEMACC_DRAIN_WRCNT_EN
   logic [15:0] r_wrCount;

   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         r_wrCount <= 16'd0;
      end else if (w_writeDone) begin
         r_wrCount <= r_wrCount + 16'd1;
      end
   end

   assign wr_count_o = r_wrCount;
`else
   assign wr_count_o = 16'd0;
`endif

   assign ft_memacc_rd_req_o = w_rdReq;
   assign mem_we_o           = (r_state == ST_WRITE);
   assign mem_addr_o         = r_addr;
   assign mem_data_o         = r_data;
   assign addr_valid_o       = r_addrValid;
   assign err_o              = r_err;

endmodule

// File: doc/memacc_fifo_drain.md
MEMACC_FIFO_DRAIN -- requirements
Module: memacc_fifo_drain

Interface
REQ-001 The block SHALL have one clock and one reset: reset SHALL be synchronous and active-high.
REQ-002 wb_clk_i  in  1  system clock; all logic on its rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 ft_memacc_rd_empty_i  in  1  MEMACC FIFO read-side empty flag.
REQ-005 ft_memacc_rd_req_o  out  1  FIFO read request; one word is popped per asserted cycle.
REQ-006 ft_memacc_ad_sel_i  in  1  entry type of the popped word: 0 = address, 1 = data.
REQ-007 ft_memacc_ad_i  in  32  popped address or data word.
REQ-008 mem_addr_o  out  32  memory write address.
REQ-009 mem_data_o  out  32  memory write data.
REQ-010 mem_we_o  out  1  write strobe; held high until acknowledged.
REQ-011 mem_ack_i  in  1  write accepted when sampled high while mem_we_o=1.
REQ-012 addr_valid_o  out  1  an address entry has been received since reset.
REQ-013 err_o  out  1  sticky; a data entry arrived before any address entry.
REQ-014 wr_count_o  out  16  number of completed memory writes.

Function
REQ-015 The FIFO read latency SHALL be one cycle: ad_sel/ad are valid in the cycle after rd_req=1.
REQ-016 The FSM SHALL have three states: IDLE, LATCH and WRITE.
REQ-017 ft_memacc_rd_req_o SHALL be combinational: 1 only when state=IDLE and ft_memacc_rd_empty_i=0.
REQ-018 IDLE->LATCH SHALL occur when rd_req=1; otherwise the FSM SHALL stay in IDLE.
REQ-019 In LATCH with ad_sel=0, the block SHALL load ft_memacc_ad_i into the address register, set addr_valid_o and go to IDLE.
REQ-020 In LATCH with ad_sel=1 and addr_valid_o=1, the block SHALL load the data register and go to WRITE.
REQ-021 In LATCH with ad_sel=1 and addr_valid_o=0, the block SHALL drop the word, set err_o and go to IDLE.
REQ-022 In WRITE, mem_we_o SHALL be 1, and mem_addr_o/mem_data_o SHALL be stable until mem_ack_i=1.
REQ-023 On WRITE with mem_ack_i=1, the block SHALL increment the address by 1 (0xFFFFFFFF wraps to 0x00000000), increment wr_count_o (0xFFFF wraps to 0) and go to IDLE.
REQ-024 mem_addr_o SHALL always show the address register, and mem_data_o SHALL always show the data register.
REQ-025 Any new address entry SHALL replace the running address; err_o SHALL remain set until reset.
REQ-026 The block SHALL never pop a word while in LATCH or WRITE, so back-pressure from mem_ack_i stalls the FIFO.
REQ-027 Minimum cost SHALL be 2 cycles per address entry and 3 cycles per data entry when ack is immediate.

Reset
REQ-028 While rst_i=1 at a clock edge, the next state SHALL be: FSM=IDLE; mem_addr_o, mem_data_o and wr_count_o = 0; mem_we_o, addr_valid_o and err_o = 0.
REQ-029 Reset SHALL take priority over every other event.
REQ-030 A reset during WRITE SHALL abandon the pending write: mem_we_o=0 on the next cycle, and wr_count_o SHALL not be incremented.
REQ-031 ft_memacc_rd_req_o SHALL be 0 in any cycle where rst_i=1.

Configuration
REQ-032 With MEMACC_DRAIN_WRCNT_EN defined, the 16-bit write counter SHALL be implemented as specified in REQ-023.
REQ-033 Without MEMACC_DRAIN_WRCNT_EN, wr_count_o SHALL be tied to 0 and no counter register SHALL exist; all other behaviour SHALL be unchanged.

Verification
REQ-034 FIFO {A:0x100, D:0x11, D:0x22}, ack immediate -> writes (0x100,0x11) then (0x101,0x22); wr_count_o=2; err_o=0.
REQ-035 FIFO {D:0xAA, A:0x10, D:0xBB} after reset -> 0xAA dropped and err_o=1; one write (0x10,0xBB); err_o stays 1.
REQ-036 FIFO {A:0xFFFFFFFF, D:1, D:2} -> writes at 0xFFFFFFFF then 0x00000000.
REQ-037 mem_ack_i held low 5 cycles with FIFO non-empty -> mem_we_o high 5+ cycles, rd_req_o=0 throughout, addr/data stable.
REQ-038 rst_i pulsed during WRITE -> next cycle: mem_we_o=0, addr_valid_o=0, wr_count_o=0, FSM=IDLE; queued FIFO words drained afterwards.
REQ-039 Build without MEMACC_DRAIN_WRCNT_EN, 3 writes -> wr_count_o=0 and writes identical to the build with the macro.
